// File: rtl/fu_iq_pkg.sv
// Shared types for the per-FU issue queue: operand slot and queue entry layouts.
// Field widths follow fu_if; the queue's width parameters default to these values.
package fu_iq_pkg;

    localparam int IQ_INST_ID_BITS = 6;
    localparam int IQ_PRN_BITS     = 6;
    localparam int IQ_MAX_OPERANDS = 3;
    localparam int IQ_XLEN         = 64;
    localparam int IQ_INST_BITS    = 32;

    typedef struct packed {
        logic                   rdy;
        logic [IQ_PRN_BITS-1:0] prn;
        logic [IQ_XLEN-1:0]     val;
    } operand_t;

    typedef struct packed {
        logic                                        valid;
        logic [IQ_INST_ID_BITS-1:0]                  inst_id;
        logic [IQ_INST_BITS-1:0]                     inst;
        logic [IQ_XLEN-1:0]                          pc;
        operand_t [IQ_MAX_OPERANDS-1:0]              src;
        logic [IQ_MAX_OPERANDS-1:0][IQ_PRN_BITS-1:0] out_prn;
    } entry_t;

    function automatic logic src_all_ready(input operand_t [IQ_MAX_OPERANDS-1:0] src);
        logic r;
        r = 1'b1;
        for (int j = 0; j < IQ_MAX_OPERANDS; j++) begin
            r = r & src[j].rdy;
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_iq_wakeup.sv
// Next-state of one operand slot given the writeback broadcast ports.
// A waiting operand captures the value of the lowest-numbered matching port.
module fu_iq_wakeup
    import fu_iq_pkg::*;
#(
    parameter int WB_PORTS = 2
) (
    input  operand_t               op_cur,
    input  logic                   wb_valid [WB_PORTS],
    input  logic [IQ_PRN_BITS-1:0] wb_prn   [WB_PORTS],
    input  logic [IQ_XLEN-1:0]     wb_value [WB_PORTS],
    output operand_t               op_nxt
);

    logic hit;

    always_comb begin
        op_nxt = op_cur;
        hit    = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (!op_cur.rdy && !hit && wb_valid[p] && (wb_prn[p] == op_cur.prn)) begin
                op_nxt.rdy = 1'b1;
                op_nxt.val = wb_value[p];
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_queue.sv
// Per-FU reservation station: collapsing queue (index 0 oldest) with wakeup
// capture and oldest-ready select, issuing at most one instruction per cycle.
module fu_issue_queue
    import fu_iq_pkg::*;
#(
    parameter int INST_ID_BITS = IQ_INST_ID_BITS,
    parameter int PRN_BITS     = IQ_PRN_BITS,
    parameter int MAX_OPERANDS = IQ_MAX_OPERANDS,
    parameter int DEPTH        = 4,
    parameter int WB_PORTS     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INST_ID_BITS-1:0]     in_inst_id,
    input  logic [31:0]                 in_inst,
    input  logic [63:0]                 in_pc,
    input  logic [PRN_BITS-1:0]         in_src_prn   [MAX_OPERANDS],
    input  logic                        in_src_ready [MAX_OPERANDS],
    input  logic [63:0]                 in_src_val   [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]         in_out_prn   [MAX_OPERANDS],
    input  logic                        wb_valid     [WB_PORTS],
    input  logic [PRN_BITS-1:0]         wb_prn       [WB_PORTS],
    input  logic [63:0]                 wb_value     [WB_PORTS],
    input  logic                        flush,
    input  logic                        fu_ready,
    output logic                        fu_inst_valid,
    output logic [INST_ID_BITS-1:0]     fu_inst_id,
    output logic [31:0]                 fu_inst,
    output logic [63:0]                 fu_pc,
    output logic [63:0]                 fu_op      [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]         fu_out_prn [MAX_OPERANDS],
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int CW = $clog2(DEPTH+1);

    entry_t   q        [DEPTH];
    entry_t   q_woke   [DEPTH];
    entry_t   q_nxt    [DEPTH];
    operand_t woke_src [DEPTH][MAX_OPERANDS];

    operand_t enq_src_cur [MAX_OPERANDS];
    operand_t enq_src_nxt [MAX_OPERANDS];
    entry_t   enq_e;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] sel_idx;
    logic          found;
    logic          issue;
    logic          enq;

    logic [INST_ID_BITS-1:0] sel_inst_id;
    logic [31:0]             sel_inst;
    logic [63:0]             sel_pc;
    logic [63:0]             sel_op  [MAX_OPERANDS];
    logic [PRN_BITS-1:0]     sel_out [MAX_OPERANDS];

    // Wakeup for every stored operand and for the incoming instruction.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        for (genvar j = 0; j < MAX_OPERANDS; j++) begin : g_op
            fu_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wakeup (
                .op_cur   (q[i].src[j]),
                .wb_valid (wb_valid),
                .wb_prn   (wb_prn),
                .wb_value (wb_value),
                .op_nxt   (woke_src[i][j])
            );
        end
    end

    for (genvar j = 0; j < MAX_OPERANDS; j++) begin : g_enq_op
        fu_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wakeup (
            .op_cur   (enq_src_cur[j]),
            .wb_valid (wb_valid),
            .wb_prn   (wb_prn),
            .wb_value (wb_value),
            .op_nxt   (enq_src_nxt[j])
        );
    end

    always_comb begin
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            enq_src_cur[j].rdy = in_src_ready[j];
            enq_src_cur[j].prn = in_src_prn[j];
            enq_src_cur[j].val = in_src_val[j];
        end
    end

    always_comb begin
        enq_e         = '0;
        enq_e.valid   = 1'b1;
        enq_e.inst_id = in_inst_id;
        enq_e.inst    = in_inst;
        enq_e.pc      = in_pc;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            enq_e.src[j]     = enq_src_nxt[j];
            enq_e.out_prn[j] = in_out_prn[j];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_woke[i] = q[i];
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                q_woke[i].src[j] = woke_src[i][j];
            end
        end
    end

    // Oldest-ready select: descending scan so the lowest index wins.
    always_comb begin
        found       = 1'b0;
        sel_idx     = '0;
        sel_inst_id = '0;
        sel_inst    = '0;
        sel_pc      = '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            sel_op[j]  = '0;
            sel_out[j] = '0;
        end
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (q[i].valid && src_all_ready(q[i].src)) begin
                found       = 1'b1;
                sel_idx     = CW'(i);
                sel_inst_id = q[i].inst_id;
                sel_inst    = q[i].inst;
                sel_pc      = q[i].pc;
                for (int j = 0; j < MAX_OPERANDS; j++) begin
                    sel_op[j]  = q[i].src[j].val;
                    sel_out[j] = q[i].out_prn[j];
                end
            end
        end
    end

    assign fu_inst_valid = found && !flush && !rst;
    assign in_ready      = (count_q < CW'(DEPTH)) && !flush && !rst;
    assign issue         = fu_inst_valid && fu_ready;
    assign enq           = in_valid && in_ready;
    assign wr_idx        = count_q - CW'(issue);
    assign count         = count_q;

    always_comb begin
        fu_inst_id = fu_inst_valid ? sel_inst_id : '0;
        fu_inst    = fu_inst_valid ? sel_inst    : '0;
        fu_pc      = fu_inst_valid ? sel_pc      : '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            fu_op[j]      = fu_inst_valid ? sel_op[j]  : '0;
            fu_out_prn[j] = fu_inst_valid ? sel_out[j] : '0;
        end
    end

    // Collapse above the issued slot, then drop the new entry at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && (CW'(i) >= sel_idx)) begin
                q_nxt[i] = (i < DEPTH-1) ? q_woke[(i < DEPTH-1) ? i+1 : i] : '0;
            end else begin
                q_nxt[i] = q_woke[i];
            end
            if (enq && (CW'(i) == wr_idx)) begin
                q_nxt[i] = enq_e;
            end
            if (flush) begin
                q_nxt[i] = '0;
            end
        end
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + CW'(enq) - CW'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
            count_q <= count_nxt;
        end
    end

endmodule
